inst_fetch_unit: RTL

Fetch-side responder to the program counter: samples the current PC, runs a single-outstanding req/ack read against instruction memory, and holds the returned word for decode. It drives the PC's pause input, so the PC advances only when an instruction has been handed downstream or a redirect is taken. It sits between the program counter, instruction memory and the decode stage of the multi-cycle CPU.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/inst_fetch_unit_if.sv | 35 +++
 rtl/inst_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, fault word, FSM state type.
package fetch_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  // Word presented to decode when a fetch faults
  localparam logic [DataW-1:0] NopInst = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } fetchState_t;

  // Instruction fetches must be word aligned
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: PC handshake, instruction-memory req/ack bus and decode handoff.
// Signal names keep the i_/o_ prefixes as seen from the fetch unit.
interface inst_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) ();

  logic [ADDR_W-1:0] i_pc;
  logic              o_pc_pause;
  logic              i_flush;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [DATA_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_pc;
  logic              o_inst_valid;
  logic              i_stall;
  logic              o_fetch_err;

  // Fetch unit side
  modport master (
    input  i_pc, i_flush, i_mem_ack, i_mem_rdata, i_stall,
    output o_pc_pause, o_mem_req, o_mem_addr, o_inst, o_inst_pc, o_inst_valid, o_fetch_err
  );

  // PC / memory / decode side
  modport slave (
    output i_pc, i_flush, i_mem_ack, i_mem_rdata, i_stall,
    input  o_pc_pause, o_mem_req, o_mem_addr, o_inst, o_inst_pc, o_inst_valid, o_fetch_err
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: latches the PC, runs one outstanding req/ack read to instruction
// memory and holds the returned word until decode takes it. Drives the PC pause input so
// the PC advances once per delivered instruction or on a redirect.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PCs skip the memory read and
// deliver NopInst with o_fetch_err set.
module inst_fetch_unit
  import fetch_pkg::*;
(
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);

  fetchState_t        state;
  logic               drop;
  logic               memReq;
  logic [AddrW-1:0]   memAddr;
  logic [DataW-1:0]   inst;
  logic [AddrW-1:0]   instPc;
  logic               instValid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               fetchErr;
`endif

  // FSM with registered outputs; a flush always wins over delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      drop      <= 1'b0;
      memReq    <= 1'b0;
      memAddr   <= '0;
      inst      <= '0;
      instPc    <= '0;
      instValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetchErr  <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          drop    <= 1'b0;
          memAddr <= bus.i_pc;
          instPc  <= bus.i_pc;
          // On a flush the PC changes at this edge, so re-latch next cycle
          if (!bus.i_flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (isMisaligned(bus.i_pc[1:0])) begin
              state     <= StHold;
              inst      <= NopInst;
              instValid <= 1'b1;
              fetchErr  <= 1'b1;
            end else begin
              state  <= StReq;
              memReq <= 1'b1;
            end
`else
            state  <= StReq;
            memReq <= 1'b1;
`endif
          end
        end
        StReq: begin
          // Request is never withdrawn; a flush only marks the data to be discarded
          if (bus.i_mem_ack) begin
            memReq <= 1'b0;
            if (drop || bus.i_flush) begin
              state <= StIdle;
            end else begin
              state     <= StHold;
              inst      <= bus.i_mem_rdata;
              instValid <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
              fetchErr  <= 1'b0;
`endif
            end
          end else if (bus.i_flush) begin
            drop <= 1'b1;
          end
        end
        StHold: begin
          if (bus.i_flush || !bus.i_stall) begin
            state     <= StIdle;
            instValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetchErr  <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.o_mem_req    = memReq;
  assign bus.o_mem_addr   = memAddr;
  assign bus.o_inst       = inst;
  assign bus.o_inst_pc    = instPc;
  assign bus.o_inst_valid = instValid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.o_fetch_err  = fetchErr;
`else
  assign bus.o_fetch_err  = 1'b0;
`endif

  // Release the PC on a redirect or when decode accepts the held instruction
  assign bus.o_pc_pause = ~(bus.i_flush | ((state == StHold) & ~bus.i_stall));

endmodule
